// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Valid/ready pipeline stage register for the riscx core. Carries a packed
//   stage payload from one core stage to the next. It supports a synchronous
//   flush, a stall input that holds back new beats only, and a saturating
//   counter of back-pressure cycles.
//
//   SKID=0 : single register. in_ready_o depends combinationally on
//            out_ready_i.
//   SKID=1 : two-entry skid buffer. in_ready_o depends only on registered
//            state, stall_i and flush_i.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   flush_i      clears all valid bits at the next edge; data is kept
//   stall_i      blocks acceptance only; held beats still drain
//   in_valid_i   upstream beat valid
//   in_ready_o   stage can accept
//   in_data_i    upstream payload [DW]
//   out_valid_o  downstream beat valid
//   out_ready_i  downstream accepts
//   out_data_o   downstream payload [DW], always from the main register
//   occ_o        number of entries held (0..2)
//   bp_cnt_o     saturating count of cycles with out_valid_o & ~out_ready_i
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DW    = 64,
  parameter int SKID  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] bp_cnt_o
);

  logic          in_xfer;
  logic          out_xfer;
  logic [DW-1:0] main_data_q, main_data_d;

  assign in_xfer    = in_valid_i & in_ready_o;
  assign out_xfer   = out_valid_o & out_ready_i;
  assign out_data_o = main_data_q;

  generate
    if (SKID == 0) begin : g_single
      logic main_valid_q, main_valid_d;

      always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush_i) begin
          main_valid_d = 1'b0;
        end else if (in_xfer) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data_i;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          main_valid_q <= 1'b0;
          main_data_q  <= '0;
        end else begin
          main_valid_q <= main_valid_d;
          main_data_q  <= main_data_d;
        end
      end

      // rst_n is folded in so the stage never advertises ready during reset.
      assign in_ready_o  = rst_n & ~flush_i & ~stall_i & (~main_valid_q | out_ready_i);
      assign out_valid_o = main_valid_q;
      assign occ_o       = {1'b0, main_valid_q};

    end else begin : g_skid
      localparam logic [1:0] EMPTY = 2'd0;
      localparam logic [1:0] ONE   = 2'd1;
      localparam logic [1:0] FULL  = 2'd2;

      // The state value equals the number of valid entries.
      logic [1:0]    state_q, state_d;
      logic [DW-1:0] skid_data_q, skid_data_d;

      // State and data registers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q     <= EMPTY;
          main_data_q <= '0;
          skid_data_q <= '0;
        end else begin
          state_q     <= state_d;
          main_data_q <= main_data_d;
          skid_data_q <= skid_data_d;
        end
      end

      // Next state and data steering
      always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (flush_i) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: begin
              if (in_xfer) begin
                state_d     = ONE;
                main_data_d = in_data_i;
              end
            end
            ONE: begin
              if (in_xfer && out_xfer) begin
                main_data_d = in_data_i;
              end else if (in_xfer) begin
                state_d     = FULL;
                skid_data_d = in_data_i;
              end else if (out_xfer) begin
                state_d = EMPTY;
              end
            end
            FULL: begin
              // in_ready_o is low here, so only the drain case exists.
              if (out_xfer) begin
                state_d     = ONE;
                main_data_d = skid_data_q;
              end
            end
            default: state_d = EMPTY;
          endcase
        end
      end

      // Outputs
      always_comb begin
        out_valid_o = (state_q == ONE) || (state_q == FULL);
        in_ready_o  = rst_n & ~flush_i & ~stall_i & (state_q != FULL);
        occ_o       = state_q;
      end
    end
  endgenerate

  // Back-pressure counter: cleared by reset only, saturates at all-ones.
  logic [CNT_W-1:0] bp_cnt_q, bp_cnt_d;

  always_comb begin
    bp_cnt_d = bp_cnt_q;
    if (out_valid_o && !out_ready_i && !(&bp_cnt_q)) begin
      bp_cnt_d = bp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bp_cnt_q <= '0;
    end else begin
      bp_cnt_q <= bp_cnt_d;
    end
  end

  assign bp_cnt_o = bp_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. Instance a is SKID=0 with DW=8, and
//   instance b is SKID=1 with DW=8 and CNT_W=3. Inputs are driven 1 time unit
//   after the rising edge, and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance a (SKID=0)
  logic        a_flush, a_stall, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_bp;

  // Instance b (SKID=1, CNT_W=3)
  logic        b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [2:0]  b_bp;

  pipe_stage_reg #(.DW(8), .SKID(0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush), .stall_i(a_stall),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .occ_o(a_occ), .bp_cnt_o(a_bp)
  );

  pipe_stage_reg #(.DW(8), .SKID(1), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .stall_i(b_stall),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .occ_o(b_occ), .bp_cnt_o(b_bp)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-22s obs=0x%0h exp=0x%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_flush = 0; a_stall = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_stall = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    tick();
    tick();

    // Reset state
    chk("a_rst_valid", 32'(a_out_valid), 0);
    chk("a_rst_data",  32'(a_out_data),  0);
    chk("a_rst_ready", 32'(a_in_ready),  0);
    chk("b_rst_valid", 32'(b_out_valid), 0);
    chk("b_rst_occ",   32'(b_occ),       0);
    chk("b_rst_bp",    32'(b_bp),        0);
    chk("b_rst_ready", 32'(b_in_ready),  0);
    rst_n = 1'b1;
    #1;
    chk("a_ready_after_rst", 32'(a_in_ready), 1);
    chk("b_ready_after_rst", 32'(b_in_ready), 1);

    // Instance a: stream 0x01..0x05 with continuous out_ready, no bubbles
    a_out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      a_in_valid = 1;
      a_in_data  = 8'(i);
      #1;
      chk("a_stream_ready", 32'(a_in_ready), 1);
      if (i > 1) begin
        chk("a_stream_valid", 32'(a_out_valid), 1);
        chk("a_stream_data",  32'(a_out_data),  32'(i - 1));
      end
      tick();
    end
    a_in_valid = 0;
    #1;
    chk("a_stream_last_data", 32'(a_out_data), 32'h05);
    chk("a_stream_last_vld",  32'(a_out_valid), 1);
    tick();
    chk("a_stream_drained", 32'(a_out_valid), 0);

    // Instance b: 0xA1, 0xA2 with out_ready low, which fills both entries
    b_in_valid = 1; b_in_data = 8'hA1;
    #1;
    chk("b_fill1_ready", 32'(b_in_ready), 1);
    tick();
    b_in_data = 8'hA2;
    #1;
    chk("b_fill2_ready", 32'(b_in_ready), 1);
    chk("b_fill2_occ",   32'(b_occ),      1);
    chk("b_fill2_data",  32'(b_out_data), 32'hA1);
    tick();
    b_in_valid = 0;
    #1;
    chk("b_full_occ",   32'(b_occ),      2);
    chk("b_full_ready", 32'(b_in_ready), 0);
    chk("b_full_data",  32'(b_out_data), 32'hA1);
    chk("b_full_bp",    32'(b_bp),       1);
    b_out_ready = 1;
    #1;
    chk("b_full_ready_no_comb", 32'(b_in_ready), 0);
    tick();
    chk("b_drain1_data", 32'(b_out_data), 32'hA2);
    chk("b_drain1_occ",  32'(b_occ),      1);
    chk("b_drain1_vld",  32'(b_out_valid), 1);
    tick();
    chk("b_drain2_occ", 32'(b_occ),       0);
    chk("b_drain2_vld", 32'(b_out_valid), 0);

    // Instance b: fill to 2, then flush with a beat offered during the flush
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 8'hB1; tick();
    b_in_data = 8'hB2; tick();
    b_flush = 1; b_in_data = 8'hCC;
    #1;
    chk("b_flush_occ_before", 32'(b_occ),      2);
    chk("b_flush_ready",      32'(b_in_ready), 0);
    tick();
    b_flush = 0; b_in_valid = 0;
    #1;
    chk("b_flush_vld",   32'(b_out_valid), 0);
    chk("b_flush_occ",   32'(b_occ),       0);
    chk("b_flush_bp",    32'(b_bp),        3);
    chk("b_flush_ready_after", 32'(b_in_ready), 1);
    b_out_ready = 1;
    tick();
    chk("b_flush_beat_lost", 32'(b_out_valid), 0);
    tick();
    chk("b_flush_beat_lost2", 32'(b_out_valid), 0);

    // Instance a: one entry held, then stall for 3 cycles with in_valid high
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 8'h33;
    tick();
    a_in_valid = 0;
    #1;
    chk("a_held_ready_blocked", 32'(a_in_ready), 0);
    a_out_ready = 1;
    #1;
    chk("a_ready_comb_path", 32'(a_in_ready), 1);
    a_stall = 1; a_in_valid = 1; a_in_data = 8'h44;
    #1;
    chk("a_stall1_ready", 32'(a_in_ready),  0);
    chk("a_stall1_vld",   32'(a_out_valid), 1);
    chk("a_stall1_data",  32'(a_out_data),  32'h33);
    tick();
    chk("a_stall2_ready", 32'(a_in_ready),  0);
    chk("a_stall2_vld",   32'(a_out_valid), 0);
    tick();
    chk("a_stall3_ready", 32'(a_in_ready),  0);
    chk("a_stall3_vld",   32'(a_out_valid), 0);
    tick();
    a_stall = 0;
    #1;
    chk("a_unstall_ready", 32'(a_in_ready), 1);
    tick();
    a_in_valid = 0;
    chk("a_unstall_vld",  32'(a_out_valid), 1);
    chk("a_unstall_data", 32'(a_out_data),  32'h44);
    tick();

    // Instance b: back-pressure counter saturation at 7 (bp is 3 here)
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 8'h55;
    tick();
    b_in_valid = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("b_bp_sat", 32'(b_bp), (3 + k > 7) ? 32'd7 : 32'(3 + k));
    end
    b_flush = 1;
    tick();
    b_flush = 0;
    chk("b_bp_after_flush",   32'(b_bp),        7);
    chk("b_vld_after_flush",  32'(b_out_valid), 0);
    chk("b_data_kept_flush",  32'(b_out_data),  32'h55);

    // Reset asserted mid-operation
    rst_n = 0;
    #1;
    chk("b_ready_in_rst", 32'(b_in_ready), 0);
    tick();
    chk("b_bp_after_rst",   32'(b_bp),       0);
    chk("b_data_after_rst", 32'(b_out_data), 0);
    chk("a_data_after_rst", 32'(a_out_data), 0);
    rst_n = 1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
